// File: rtl/sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
package sub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefaultWidth = 8;

  // Bit counter must be at least one bit wide, even for WIDTH=1.
  function automatic int unsigned cnt_width(int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  assign diff_o = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full_subtractor cell stepped LSB first,
// with a start/ready/done handshake.
module serial_subtractor_ctrl
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, part_q, part_d;
  logic [CntW-1:0]  cnt_q;
  logic             borrow_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             cell_diff, cell_bout;

  full_subtractor u_cell (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .bin_i  (borrow_q),
    .diff_o (cell_diff),
    .bout_o (cell_bout)
  );

  // Cell output enters at the MSB so the last bit processed lands in place.
  if (WIDTH > 1) begin : g_part_wide
    assign part_d = {cell_diff, part_q[WIDTH-1:1]};
  end else begin : g_part_one
    assign part_d = cell_diff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StRun;
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            part_q   <= '0;
            cnt_q    <= '0;
          end
        end
        StRun: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          part_q   <= part_d;
          borrow_q <= cell_bout;
          cnt_q    <= cnt_q + CntW'(1);
          if (cnt_q == LastBit) begin
            state_q <= StDone;
            diff_q  <= part_d;
            bout_q  <= cell_bout;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready = (state_q == StIdle);
  assign busy  = (state_q == StRun) || (state_q == StDone);
  assign done  = (state_q == StDone);
  assign diff  = diff_q;
  assign bout  = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed self-checking bench for serial_subtractor_ctrl at WIDTH=8, 2 and 1.
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0, bin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start2 = 1'b0, bin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       ready2, busy2, done2, bout2;
  logic [1:0] diff2;

  logic       start1 = 1'b0, bin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ready1, busy1, done1, bout1;
  logic [0:0] diff1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .ready(ready2), .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .ready(ready1), .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one WIDTH=8 operation from IDLE and check latency, pulse width and result.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                     input logic [7:0] exp_d, input logic exp_b, input string tag);
    int n;
    a8 = av; b8 = bv; bin8 = cv; start8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = ~av; b8 = ~bv; bin8 = ~cv;
    chk({tag, "_busy"}, {31'd0, busy8}, 32'd1);
    n = 0;
    while (!done8 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, 32'd8);
    chk({tag, "_diff"}, {24'd0, diff8}, {24'd0, exp_d});
    chk({tag, "_bout"}, {31'd0, bout8}, {31'd0, exp_b});
    tick();
    chk({tag, "_done_drop"}, {31'd0, done8}, 32'd0);
    chk({tag, "_ready"}, {31'd0, ready8}, 32'd1);
    chk({tag, "_hold"}, {24'd0, diff8}, {24'd0, exp_d});
  endtask

  initial begin
    int n, dones, last, r;
    logic [7:0] seen;

    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", {31'd0, ready8}, 32'd1);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_diff", {24'd0, diff8}, 32'd0);
    chk("rst_bout", {31'd0, bout8}, 32'd0);

    op8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "op_5a_3c");
    op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "op_00_01");
    op8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, "op_10_0f_b");

    // start pulsed during the second RUN cycle must be ignored.
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    dones = 0;
    seen = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done8) begin
        dones++;
        seen = diff8;
      end
    end
    chk("ign_dones", dones, 32'd1);
    chk("ign_diff", {24'd0, seen}, 32'h7F);
    chk("ign_bout", {31'd0, bout8}, 32'd0);

    // Reset in the fourth RUN cycle discards the operation.
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", {31'd0, ready8}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy8}, 32'd0);
    chk("mid_rst_diff", {24'd0, diff8}, 32'd0);
    chk("mid_rst_bout", {31'd0, bout8}, 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) dones++;
    end
    chk("mid_rst_nodone", dones, 32'd0);

    // start held high: back-to-back operations every WIDTH+2 cycles.
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
    dones = 0;
    last = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (last >= 0) chk("hold_diff_stable", {24'd0, diff8}, 32'h1E);
      if (done8) begin
        if (last >= 0) chk("hold_spacing", cyc - last, 32'd10);
        last = cyc;
        dones++;
      end
    end
    start8 = 1'b0;
    chk("hold_count", {31'd0, dones >= 3}, 32'd1);
    for (int i = 0; i < 12; i++) tick();

    // WIDTH=2 exhaustive against a behavioural model.
    for (int ai = 0; ai < 4; ai++) begin
      for (int bi = 0; bi < 4; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a2 = ai[1:0]; b2 = bi[1:0]; bin2 = ci[0]; start2 = 1'b1;
          tick();
          start2 = 1'b0;
          n = 0;
          while (!done2 && n < 10) begin
            tick();
            n++;
          end
          r = ai - bi - ci;
          chk("w2_lat", n, 32'd2);
          chk("w2_diff", {30'd0, diff2}, {30'd0, r[1:0]});
          chk("w2_bout", {31'd0, bout2}, (r < 0) ? 32'd1 : 32'd0);
          tick();
        end
      end
    end

    // WIDTH=1 exhaustive: RUN lasts a single cycle.
    for (int ai = 0; ai < 2; ai++) begin
      for (int bi = 0; bi < 2; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a1 = ai[0]; b1 = bi[0]; bin1 = ci[0]; start1 = 1'b1;
          tick();
          start1 = 1'b0;
          n = 0;
          while (!done1 && n < 10) begin
            tick();
            n++;
          end
          r = ai - bi - ci;
          chk("w1_lat", n, 32'd1);
          chk("w1_diff", {31'd0, diff1}, {31'd0, r[0]});
          chk("w1_bout", {31'd0, bout1}, (r < 0) ? 32'd1 : 32'd0);
          tick();
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
